// File: rtl/thresh_pwm_ctrl.sv
// Threshold PWM controller: two 8-bit threshold codes encoded as 1024-clock PWM
// waveforms, with ordered, period-aligned updates through a single write port.
module thresh_pwm_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wrt,
  input  logic       sel_VIH,
  input  logic [7:0] wdata,
  output logic       rdy,
  output logic       err,
  output logic       VIL_PWM,
  output logic       VIH_PWM,
  output logic       settled
);

  logic [9:0] cnt_q, cnt_d;
  logic [7:0] vil_act_q, vil_act_d, vih_act_q, vih_act_d;
  logic [7:0] vil_pnd_q, vil_pnd_d, vih_pnd_q, vih_pnd_d;
  logic       vil_vld_q, vil_vld_d, vih_vld_q, vih_vld_d;
  logic       rdy_q, rdy_d, err_q, err_d;
  logic       vil_pwm_q, vil_pwm_d, vih_pwm_q, vih_pwm_d;
  logic       seen_wrap_q, seen_wrap_d, settled_q, settled_d;
  logic       wrap, apply, order_ok, accept;

  always_comb begin
    cnt_d       = cnt_q + 10'd1;
    vil_act_d   = vil_act_q;
    vih_act_d   = vih_act_q;
    vil_pnd_d   = vil_pnd_q;
    vih_pnd_d   = vih_pnd_q;
    vil_vld_d   = vil_vld_q;
    vih_vld_d   = vih_vld_q;
    seen_wrap_d = seen_wrap_q;
    settled_d   = settled_q;

    wrap  = (cnt_q == 10'd1023);
    apply = wrap & (vil_vld_q | vih_vld_q);

    if (wrap && vil_vld_q) begin
      vil_act_d = vil_pnd_q;
      vil_vld_d = 1'b0;
    end
    if (wrap && vih_vld_q) begin
      vih_act_d = vih_pnd_q;
      vih_vld_d = 1'b0;
    end

    // Ordering is judged against the active pair; with rdy high nothing is pending.
    order_ok = sel_VIH ? (wdata > vil_act_q) : (wdata < vih_act_q);
    accept   = wrt & rdy_q & order_ok;
    if (accept) begin
      if (sel_VIH) begin
        vih_pnd_d = wdata;
        vih_vld_d = 1'b1;
      end else begin
        vil_pnd_d = wdata;
        vil_vld_d = 1'b1;
      end
    end
    err_d = wrt & ~accept;
    rdy_d = ~(vil_vld_d | vih_vld_d);

    // The apply wrap itself does not count; settle on the second wrap after it.
    if (apply) begin
      seen_wrap_d = 1'b0;
      settled_d   = 1'b0;
    end else if (wrap) begin
      if (seen_wrap_q) settled_d = 1'b1;
      else             seen_wrap_d = 1'b1;
    end

    vil_pwm_d = (cnt_d < {vil_act_d, 2'b00});
    vih_pwm_d = (cnt_d < {vih_act_d, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= 10'd0;
      vil_act_q   <= 8'h55;
      vih_act_q   <= 8'hAA;
      vil_pnd_q   <= 8'h00;
      vih_pnd_q   <= 8'h00;
      vil_vld_q   <= 1'b0;
      vih_vld_q   <= 1'b0;
      rdy_q       <= 1'b1;
      err_q       <= 1'b0;
      vil_pwm_q   <= 1'b0;
      vih_pwm_q   <= 1'b0;
      seen_wrap_q <= 1'b0;
      settled_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      vil_act_q   <= vil_act_d;
      vih_act_q   <= vih_act_d;
      vil_pnd_q   <= vil_pnd_d;
      vih_pnd_q   <= vih_pnd_d;
      vil_vld_q   <= vil_vld_d;
      vih_vld_q   <= vih_vld_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
      vil_pwm_q   <= vil_pwm_d;
      vih_pwm_q   <= vih_pwm_d;
      seen_wrap_q <= seen_wrap_d;
      settled_q   <= settled_d;
    end
  end

  assign rdy     = rdy_q;
  assign err     = err_q;
  assign VIL_PWM = vil_pwm_q;
  assign VIH_PWM = vih_pwm_q;
  assign settled = settled_q;

endmodule

// File: tb/tb_thresh_pwm_ctrl.sv
// Bench for thresh_pwm_ctrl: a period-level behavioural model predicts every
// output vector {VIL_PWM, VIH_PWM, rdy, err, settled}; scenarios check against it.
module tb_thresh_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wrt = 1'b0;
  logic       sel_VIH = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rdy, err, VIL_PWM, VIH_PWM, settled;

  int checks = 0;
  int errors = 0;

  int m_cnt, m_vil, m_vih, m_wraps, m_pend_code;
  bit m_pend, m_pend_sel, m_err, m_fresh;

  always #5 clk = ~clk;

  thresh_pwm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .sel_VIH(sel_VIH), .wdata(wdata),
    .rdy(rdy), .err(err), .VIL_PWM(VIL_PWM), .VIH_PWM(VIH_PWM), .settled(settled)
  );

  // Expected outputs for the current cycle, straight from the waveform rules.
  function automatic logic [4:0] exp_vec();
    logic vil_hi, vih_hi;
    vil_hi = !m_fresh && (m_cnt < 4 * m_vil);
    vih_hi = !m_fresh && (m_cnt < 4 * m_vih);
    return {vil_hi, vih_hi, !m_pend, m_err, (m_wraps >= 2)};
  endfunction

  task automatic tick(input bit w, input bit s, input int d);
    bit accept;
    wrt = w; sel_VIH = s; wdata = d[7:0];
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_vil = 'h55; m_vih = 'hAA; m_wraps = 0;
      m_pend = 0; m_err = 0; m_fresh = 1;
    end else begin
      accept = w && !m_pend && (s ? (d > m_vil) : (d < m_vih));
      if (m_cnt == 1023) begin
        if (m_pend) begin
          if (m_pend_sel) m_vih = m_pend_code;
          else            m_vil = m_pend_code;
          m_pend = 0;
          m_wraps = 0;
        end else if (m_wraps < 2) begin
          m_wraps++;
        end
      end
      if (accept) begin
        m_pend = 1; m_pend_sel = s; m_pend_code = d;
      end
      m_err = w && !accept;
      m_cnt = (m_cnt + 1) % 1024;
      m_fresh = 0;
    end
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(0, 0, 0);
    tick(0, 0, 0);
    checks++;
    if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL reset_vec got %b want %b", {VIL_PWM, VIH_PWM, rdy, err, settled}, 5'b00100);
    end
    rst_n = 1'b1;
    checks++;
    if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_release got %b want %b", {VIL_PWM, VIH_PWM, rdy, err, settled}, exp_vec());
    end
  endtask

  task automatic test_default_periods();
    int hi_l = 0, hi_h = 0;
    for (int i = 0; i < 2048; i++) begin
      checks++;
      if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL default_cyc%0d got %b want %b", i, {VIL_PWM, VIH_PWM, rdy, err, settled}, exp_vec());
      end
      if (i >= 1024) begin hi_l += VIL_PWM; hi_h += VIH_PWM; end
      tick(0, 0, 0);
    end
    checks++;
    if (hi_l != 340 || hi_h != 680) begin
      errors++;
      $display("[TB] FAIL default_high got %0d/%0d want 340/680", hi_l, hi_h);
    end
    checks++;
    if (settled !== 1'b1) begin
      errors++;
      $display("[TB] FAIL settled_at_2048 got %b want 1", settled);
    end
  endtask

  task automatic test_write_vil();
    int hi_l = 0;
    for (int i = 0; i < 1024 && m_cnt != 100; i++) tick(0, 0, 0);
    tick(1, 0, 'h40);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_rdy_low got %b want 0", rdy);
    end
    for (int i = 0; i < 1024 && m_cnt != 0; i++) begin
      checks++;
      if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL write_wait cnt%0d got %b want %b", m_cnt, {VIL_PWM, VIH_PWM, rdy, err, settled}, exp_vec());
      end
      tick(0, 0, 0);
    end
    checks++;
    if (rdy !== 1'b1 || settled !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_apply rdy/settled got %b%b want 10", rdy, settled);
    end
    for (int i = 0; i < 2048; i++) begin
      checks++;
      if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL write_run cyc%0d got %b want %b", i, {VIL_PWM, VIH_PWM, rdy, err, settled}, exp_vec());
      end
      if (i < 1024) hi_l += VIL_PWM;
      tick(0, 0, 0);
    end
    checks++;
    if (hi_l != 256 || settled !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_result high=%0d settled=%b want 256/1", hi_l, settled);
    end
  endtask

  task automatic test_reject_order();
    int hi_l = 0;
    tick(1, 0, 'hB0);
    checks++;
    if (err !== 1'b1 || rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL order_err err/rdy got %b%b want 11", err, rdy);
    end
    tick(0, 0, 0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL order_err_width got %b want 0", err);
    end
    for (int i = 0; i < 1024 && m_cnt != 0; i++) tick(0, 0, 0);
    for (int i = 0; i < 1024; i++) begin
      checks++;
      if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL order_run cyc%0d got %b want %b", i, {VIL_PWM, VIH_PWM, rdy, err, settled}, exp_vec());
      end
      hi_l += VIL_PWM;
      tick(0, 0, 0);
    end
    checks++;
    if (hi_l != 340) begin
      errors++;
      $display("[TB] FAIL order_vil_high got %0d want 340", hi_l);
    end
  endtask

  task automatic test_busy_write();
    int hi_l = 0, hi_h = 0;
    tick(1, 0, 'h30);
    tick(1, 1, 'hF0);
    checks++;
    if (err !== 1'b1 || rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_err err/rdy got %b%b want 10", err, rdy);
    end
    for (int i = 0; i < 1024 && m_cnt != 0; i++) tick(0, 0, 0);
    for (int i = 0; i < 1024; i++) begin
      checks++;
      if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL busy_run cyc%0d got %b want %b", i, {VIL_PWM, VIH_PWM, rdy, err, settled}, exp_vec());
      end
      hi_l += VIL_PWM; hi_h += VIH_PWM;
      tick(0, 0, 0);
    end
    checks++;
    if (hi_l != 192 || hi_h != 680) begin
      errors++;
      $display("[TB] FAIL busy_high got %0d/%0d want 192/680", hi_l, hi_h);
    end
  endtask

  task automatic test_write_at_wrap();
    int hi_a = 0, hi_b = 0;
    for (int i = 0; i < 1024 && m_cnt != 1023; i++) tick(0, 0, 0);
    tick(1, 1, 'hC0);
    checks++;
    if (rdy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_accept rdy/err got %b%b want 00", rdy, err);
    end
    for (int i = 0; i < 2048; i++) begin
      checks++;
      if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL wrap_run cyc%0d got %b want %b", i, {VIL_PWM, VIH_PWM, rdy, err, settled}, exp_vec());
      end
      if (i < 1024) hi_a += VIH_PWM; else hi_b += VIH_PWM;
      tick(0, 0, 0);
    end
    checks++;
    if (hi_a != 680 || hi_b != 768) begin
      errors++;
      $display("[TB] FAIL wrap_high got %0d/%0d want 680/768", hi_a, hi_b);
    end
  endtask

  task automatic test_extremes();
    int hi_l = 0, hi_h = 0;
    tick(1, 0, 'h00);
    for (int i = 0; i < 1024 && m_cnt != 0; i++) tick(0, 0, 0);
    tick(1, 1, 'hFF);
    for (int i = 0; i < 1024 && m_cnt != 0; i++) tick(0, 0, 0);
    for (int i = 0; i < 1024; i++) begin
      checks++;
      if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL extreme_run cnt%0d got %b want %b", m_cnt, {VIL_PWM, VIH_PWM, rdy, err, settled}, exp_vec());
      end
      hi_l += VIL_PWM; hi_h += VIH_PWM;
      tick(0, 0, 0);
    end
    checks++;
    if (hi_l != 0 || hi_h != 1020) begin
      errors++;
      $display("[TB] FAIL extreme_high got %0d/%0d want 0/1020", hi_l, hi_h);
    end
  endtask

  task automatic test_reset_pending();
    int hi_l = 0, hi_h = 0;
    tick(1, 0, 'h10);
    for (int i = 0; i < 1024 && m_cnt != 600; i++) tick(0, 0, 0);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstpend_pending rdy got %b want 0", rdy);
    end
    rst_n = 1'b0;
    tick(0, 0, 0);
    rst_n = 1'b1;
    checks++;
    if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL rstpend_vec got %b want %b", {VIL_PWM, VIH_PWM, rdy, err, settled}, 5'b00100);
    end
    for (int i = 0; i < 2048; i++) begin
      checks++;
      if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL rstpend_run cyc%0d got %b want %b", i, {VIL_PWM, VIH_PWM, rdy, err, settled}, exp_vec());
      end
      if (i >= 1024) begin hi_l += VIL_PWM; hi_h += VIH_PWM; end
      tick(0, 0, 0);
    end
    checks++;
    if (hi_l != 340 || hi_h != 680 || rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstpend_result %0d/%0d rdy=%b want 340/680 rdy=1", hi_l, hi_h, rdy);
    end
  endtask

  task automatic test_random();
    bit w;
    for (int i = 0; i < 6000; i++) begin
      w = ($urandom_range(0, 39) == 0);
      tick(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      checks++;
      if ({VIL_PWM, VIH_PWM, rdy, err, settled} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random cyc%0d cnt%0d got %b want %b", i, m_cnt, {VIL_PWM, VIH_PWM, rdy, err, settled}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_periods();
    test_write_vil();
    test_reset();
    test_reject_order();
    test_busy_write();
    test_write_at_wrap();
    test_extremes();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thresh_pwm_ctrl.md
THRESH_PWM_CTRL -- requirements
Module: thresh_pwm_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock; all flops are clocked on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port wrt, input, 1 bit: single-cycle write strobe.
REQ-004 The block SHALL have the port sel_VIH, input, 1 bit: write target (0 = VIL duty, 1 = VIH duty); sampled with wrt.
REQ-005 The block SHALL have the port wdata, input, 8 bits: requested threshold code (0x00..0xFF, full scale = 0xFF); sampled with wrt.
REQ-006 The block SHALL have the port rdy, output, 1 bit: high when no threshold update is pending.
REQ-007 The block SHALL have the port err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-008 The block SHALL have the port VIL_PWM, output, 1 bit: PWM encoding of the active VIL code to the analog front end.
REQ-009 The block SHALL have the port VIH_PWM, output, 1 bit: PWM encoding of the active VIH code to the analog front end.
REQ-010 The block SHALL have the port settled, output, 1 bit: high once the front end has seen at least two full periods of the current active codes.
REQ-011 VIL_PWM, VIH_PWM, rdy and settled SHALL each be driven directly by a flop, with no combinational output path.

Function
REQ-012 The block SHALL contain a free-running 10-bit period counter, cnt, that increments every clock and wraps 1023 -> 0, giving a 1024-clock PWM period.
REQ-013 The block SHALL hold active codes VIL_act and VIH_act, and pending codes VIL_pnd and VIH_pnd, each with a valid bit.
REQ-014 In the cycle where cnt == k, VIL_PWM SHALL equal (k < 4*VIL_act) and VIH_PWM SHALL equal (k < 4*VIH_act); the comparison is 10-bit unsigned, with the code zero-extended and shifted left by 2.
REQ-015 A code of 0x00 SHALL hold the output low for the whole period.
REQ-016 A code of 0xFF SHALL hold the output high for cnt 0..1019 and low for cnt 1020..1023.
REQ-017 Every high pulse SHALL begin at cnt == 0, so a downstream counter of high clocks, taking bits [9:2], recovers the code exactly.
REQ-018 A write SHALL be accepted only when wrt = 1, rdy = 1 and the ordering check passes.
REQ-019 The ordering check SHALL pass only if the resulting pair satisfies VIL < VIH; for sel_VIH = 0 this means wdata < VIH_act, and for sel_VIH = 1 it means wdata > VIL_act.
REQ-020 On an accepted write, the block SHALL load the selected pending code, set its valid bit, and drive rdy low on the next cycle.
REQ-021 A rejected write (rdy = 0 or ordering violation) SHALL assert err for exactly one cycle, in the cycle after wrt, and leave all state unchanged.
REQ-022 Apply: in the cycle where cnt == 1023 and a pending valid bit is set, the block SHALL copy the pending code to the active code and clear the valid bit, so the new code governs the period starting at cnt == 0.
REQ-023 rdy SHALL return high in the cycle where cnt == 0 following the apply.
REQ-024 If wrt arrives in the cycle where cnt == 1023 and rdy = 1, the write SHALL be accepted and applied at the next cnt == 1023, not the current one.
REQ-025 settled SHALL clear in the cycle after an apply.
REQ-026 settled SHALL set at the second cnt 1023 -> 0 wrap that follows the apply (or that follows reset) with no intervening apply.
REQ-027 settled SHALL then remain high until the next apply.
REQ-028 Write-to-visible latency SHALL be between 2 and 1025 clocks, depending on the value of cnt at the time of the write.
REQ-029 There SHALL be no simultaneous-write case: the single write port admits one update per period.

Reset
REQ-030 While rst_n = 0 at a rising clk edge, the block SHALL load cnt = 0, VIL_act = 0x55, VIH_act = 0xAA, both pending valid bits = 0, rdy = 1, err = 0, settled = 0, VIL_PWM = 0 and VIH_PWM = 0.
REQ-031 A reset asserted mid-period or while an update is pending SHALL discard the pending update.
REQ-032 PWM generation SHALL restart from cnt = 0 on the first cycle with rst_n = 1, using the default codes.

Verification
REQ-033 Reset then run 2 periods: VIL_PWM is high for 340 clocks and VIH_PWM for 680 clocks per period, and settled rises at clock 2048.
REQ-034 Write sel_VIH = 0, wdata = 0x40 at cnt = 100: rdy falls, VIL_PWM high time becomes 256 clocks from the next period, rdy rises at cnt = 0, and settled clears and then rises two wraps later.
REQ-035 Write sel_VIH = 0, wdata = 0xB0 while VIH_act = 0xAA: err pulses once, and the VIL_PWM high time stays at 340 clocks.
REQ-036 A second write while rdy = 0: err pulses, and the first pending value is applied unchanged.
REQ-037 Write at cnt = 1023: the new code is not applied at that wrap; it is applied one full period later.
REQ-038 rst_n low at cnt = 600 with an update pending: the defaults are restored, no apply occurs, and rdy = 1.
